// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer.
//   opcode_e    : ALU operation code (ADD, MUL, OR, AND)
//   alu_cmd_t   : one queued command (opcode plus both operands)
//   seq_state_e : issue/capture FSM states
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_MUL = 2'd1,
        OP_OR  = 2'd2,
        OP_AND = 2'd3
    } opcode_e;

    typedef struct packed {
        opcode_e    opcode;
        logic [7:0] a;
        logic [7:0] b;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer. Stores alu_cmd_t entries.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push, din    : write din at the tail (ignored when full)
//   pop, dout    : dout shows the head; pop advances it (ignored when empty)
//   count        : occupancy, 0..DEPTH
//   full, empty  : derived from count
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  alu_cmd_t                     din,
    output alu_cmd_t                     dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    alu_cmd_t          mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers are PW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Upstream command stage for the 8-bit two-operand ALU. Buffers commands,
// issues one op_start pulse per command, waits RESULT_LAT cycles, captures
// the 16-bit ALU result and presents it on a valid/ready port, in order,
// one command in flight at a time.
// Ports:
//   clk, rst                              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_opcode/a/b   : command input handshake
//   alu_op_start, alu_a/b/opcode, alu_out : ALU interface
//   res_valid/res_ready, res_data/opcode  : result output handshake
//   cmd_count                             : FIFO occupancy
//   busy                                  : FSM not in IDLE
//
// state | meaning
// IDLE  | nothing in flight; issue head of FIFO if present
// ISSUE | alu_op_start high for this one cycle; operands stable
// WAIT  | counting down RESULT_LAT; capture alu_out when it hits zero
// HOLD  | result presented until consumer accepts it
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int RESULT_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_opcode,
    input  logic [7:0]                   cmd_a,
    input  logic [7:0]                   cmd_b,
    output logic                         alu_op_start,
    output logic [7:0]                   alu_a,
    output logic [7:0]                   alu_b,
    output logic [1:0]                   alu_opcode,
    input  logic [15:0]                  alu_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [15:0]                  res_data,
    output logic [1:0]                   res_opcode,
    output logic [$clog2(DEPTH+1)-1:0]   cmd_count,
    output logic                         busy
);

    localparam int CNT_W = $clog2(RESULT_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RESULT_LAT);

    seq_state_e        state_q,     state_d;
    alu_cmd_t          alu_cmd_q,   alu_cmd_d;
    logic              op_start_q,  op_start_d;
    logic [CNT_W-1:0]  wait_q,      wait_d;
    logic              res_valid_q, res_valid_d;
    logic [15:0]       res_data_q,  res_data_d;
    logic [1:0]        res_opcode_q, res_opcode_d;

    alu_cmd_t          fifo_din;
    alu_cmd_t          fifo_dout;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign fifo_din  = '{opcode: opcode_e'(cmd_opcode), a: cmd_a, b: cmd_b};
    // Ready comes only from the registered count, never from res_ready.
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (cmd_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        alu_cmd_d    = alu_cmd_q;
        op_start_d   = 1'b0;
        wait_d       = wait_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_opcode_d = res_opcode_q;
        fifo_pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    alu_cmd_d  = fifo_dout;
                    op_start_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wait_d  = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                wait_d = wait_q - CNT_W'(1);
                if (wait_q == CNT_W'(1)) begin
                    res_data_d   = alu_out;
                    res_opcode_d = alu_cmd_q.opcode;
                    res_valid_d  = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    // Chain straight into the next issue to avoid an IDLE bubble.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        alu_cmd_d  = fifo_dout;
                        op_start_d = 1'b1;
                        state_d    = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_cmd_q    <= '0;
            op_start_q   <= 1'b0;
            wait_q       <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_opcode_q <= '0;
        end else begin
            state_q      <= state_d;
            alu_cmd_q    <= alu_cmd_d;
            op_start_q   <= op_start_d;
            wait_q       <= wait_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_opcode_q <= res_opcode_d;
        end
    end

    assign alu_op_start = op_start_q;
    assign alu_a        = alu_cmd_q.a;
    assign alu_b        = alu_cmd_q.b;
    assign alu_opcode   = alu_cmd_q.opcode;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_opcode   = res_opcode_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer. Two instances: RESULT_LAT=1 (main)
// and RESULT_LAT=3 (latency check). Each has a behavioural ALU that only
// drives a meaningful OUT in the cycle(s) the result is defined.
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_opcode;
    logic [7:0]  cmd_a, cmd_b;
    logic        alu_op_start;
    logic [7:0]  alu_a, alu_b;
    logic [1:0]  alu_opcode;
    logic [15:0] alu_out;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_opcode;
    logic [2:0]  cmd_count;
    logic        busy;

    logic        c3_valid, c3_ready;
    logic [1:0]  c3_opcode;
    logic [7:0]  c3_a, c3_b;
    logic        alu3_start;
    logic [7:0]  alu3_a, alu3_b;
    logic [1:0]  alu3_opcode;
    logic [15:0] alu3_out;
    logic        r3_valid, r3_ready;
    logic [15:0] r3_data;
    logic [1:0]  r3_opcode;
    logic [2:0]  c3_count;
    logic        busy3;

    alu_cmd_sequencer #(.DEPTH(4), .RESULT_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_op_start(alu_op_start), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_opcode(res_opcode), .cmd_count(cmd_count), .busy(busy)
    );

    alu_cmd_sequencer #(.DEPTH(4), .RESULT_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_opcode(c3_opcode),
        .cmd_a(c3_a), .cmd_b(c3_b),
        .alu_op_start(alu3_start), .alu_a(alu3_a), .alu_b(alu3_b),
        .alu_opcode(alu3_opcode), .alu_out(alu3_out),
        .res_valid(r3_valid), .res_ready(r3_ready), .res_data(r3_data),
        .res_opcode(r3_opcode), .cmd_count(c3_count), .busy(busy3)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [17:0] exp_q[$];
    int issue_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return 16'(a) + 16'(b);
            2'd1:    return 16'(a) * 16'(b);
            2'd2:    return {8'h00, a | b};
            default: return {8'h00, a & b};
        endcase
    endfunction

    // ALU models: OUT is the result RESULT_LAT cycles after op_start is
    // sampled, and a junk value whenever no result is due.
    logic [15:0] p1;
    logic        v1 = 1'b0;
    always @(posedge clk) begin
        p1 <= ref_alu(alu_opcode, alu_a, alu_b);
        v1 <= alu_op_start;
    end
    assign alu_out = v1 ? p1 : 16'hDEAD;

    logic [15:0] p3 [3];
    logic [2:0]  v3 = 3'b000;
    always @(posedge clk) begin
        p3[0] <= ref_alu(alu3_opcode, alu3_a, alu3_b);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        v3    <= {v3[1:0], alu3_start};
    end
    assign alu3_out = v3[2] ? p3[2] : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Monitor: pops the scoreboard on each result handshake, checks HOLD
    // stability and that op_start is a single-cycle pulse.
    logic        prev_hold  = 1'b0;
    logic        prev_start = 1'b0;
    logic [17:0] prev_res   = '0;
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            prev_hold  = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (prev_hold)
                check("hold_stable", {13'd0, res_valid, res_opcode, res_data}, {13'd0, 1'b1, prev_res});
            if (prev_start)
                check("op_start_pulse", {31'd0, alu_op_start}, 32'd0);
            if (alu_op_start) issue_cyc.push_back(cyc);
            if (res_valid && res_ready) begin
                check("result_pending", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0)
                    check("result", {14'd0, res_opcode, res_data}, {14'd0, exp_q.pop_front()});
            end
            prev_hold  = res_valid && !res_ready;
            prev_res   = {res_opcode, res_data};
            prev_start = alu_op_start;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int  t;
        bit  acc;
        t = 0;
        acc = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        while (!acc && t < 50) begin
            acc = cmd_ready;
            if (acc) exp_q.push_back({op, ref_alu(op, a, b)});
            tick();
            t++;
        end
        cmd_valid = 1'b0;
        if (!acc) check("send_accept", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!res_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset(input string p);
        check({p, "_op_start"},  {31'd0, alu_op_start}, 32'd0);
        check({p, "_alu_a"},     {24'd0, alu_a},        32'd0);
        check({p, "_alu_b"},     {24'd0, alu_b},        32'd0);
        check({p, "_alu_opc"},   {30'd0, alu_opcode},   32'd0);
        check({p, "_res_valid"}, {31'd0, res_valid},    32'd0);
        check({p, "_res_data"},  {16'd0, res_data},     32'd0);
        check({p, "_res_opc"},   {30'd0, res_opcode},   32'd0);
        check({p, "_busy"},      {31'd0, busy},         32'd0);
        check({p, "_count"},     {29'd0, cmd_count},    32'd0);
        check({p, "_cmd_ready"}, {31'd0, cmd_ready},    32'd1);
    endtask

    bit rand_done = 1'b0;

    initial begin
        int n;
        logic [17:0] head;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_opcode = 2'd0; cmd_a = 8'd0; cmd_b = 8'd0; res_ready = 1'b0;
        c3_valid = 1'b0;  c3_opcode = 2'd0;  c3_a = 8'd0;  c3_b = 8'd0;  r3_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Single ADD, latency and one-cycle issue pulse.
        res_ready = 1'b1;
        issue_cyc.delete();
        send(2'd0, 8'hFF, 8'hFF);
        wait_valid(n);
        check("t1_latency", n, 32'd3);
        check("t1_data", {16'd0, res_data}, 32'h01FE);
        check("t1_opcode", {30'd0, res_opcode}, 32'd0);
        drain("t1_drain");
        repeat (3) tick();
        check("t1_issues", issue_cyc.size(), 32'd1);

        // Back-to-back MUL, OR, AND.
        issue_cyc.delete();
        send(2'd1, 8'hFF, 8'hFF);
        send(2'd2, 8'hA5, 8'h5A);
        send(2'd3, 8'hF0, 8'h3C);
        drain("t2_drain");
        repeat (3) tick();
        check("t2_issues", issue_cyc.size(), 32'd3);
        if (issue_cyc.size() == 3) begin
            check("t2_gap0", issue_cyc[1] - issue_cyc[0], 32'd3);
            check("t2_gap1", issue_cyc[2] - issue_cyc[1], 32'd3);
        end

        // Fill under backpressure.
        res_ready = 1'b0;
        send(2'd0, 8'h11, 8'h22);
        send(2'd1, 8'h03, 8'h04);
        send(2'd2, 8'h0F, 8'hF0);
        send(2'd3, 8'hCC, 8'hAA);
        send(2'd0, 8'h80, 8'h80);
        check("t3_count_full", {29'd0, cmd_count}, 32'd4);
        check("t3_ready_full", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b1; cmd_opcode = 2'd1; cmd_a = 8'h55; cmd_b = 8'h66;
        repeat (3) begin
            tick();
            check("t3_sixth_blocked", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        check("t3_count_after", {29'd0, cmd_count}, 32'd4);
        wait_valid(n);
        head = exp_q[0];
        repeat (10) tick();
        check("t3_hold_valid", {31'd0, res_valid}, 32'd1);
        check("t3_hold_data", {14'd0, res_opcode, res_data}, {14'd0, head});
        res_ready = 1'b1;
        drain("t3_drain");

        // Toggled backpressure during HOLD.
        res_ready = 1'b0;
        send(2'd1, 8'h7F, 8'h81);
        send(2'd0, 8'hC3, 8'h3C);
        wait_valid(n);
        for (int i = 0; i < 8; i++) begin
            res_ready = (i % 2) != 0;
            tick();
        end
        res_ready = 1'b1;
        drain("t4_drain");

        // Random traffic with random consumer backpressure.
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    res_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
        join
        res_ready = 1'b1;
        drain("rand_drain");
        repeat (3) tick();

        // Reset during WAIT with two commands queued.
        send(2'd0, 8'h01, 8'h01);
        send(2'd1, 8'h02, 8'h02);
        send(2'd2, 8'h03, 8'h03);
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        check("t5_start_pre", {31'd0, alu_op_start}, 32'd0);
        check("t5_count_pre", {29'd0, cmd_count}, 32'd2);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check_reset("t5_reset");
        rst = 1'b0;
        repeat (6) begin
            tick();
            check("t5_no_result", {31'd0, res_valid}, 32'd0);
        end
        send(2'd0, 8'h01, 8'h02);
        wait_valid(n);
        check("t5_add_data", {16'd0, res_data}, 32'h0003);
        drain("t5_drain");

        // RESULT_LAT=3 instance.
        check("t6_ready", {31'd0, c3_ready}, 32'd1);
        c3_valid = 1'b1; c3_opcode = 2'd1; c3_a = 8'h10; c3_b = 8'h10;
        tick();
        c3_valid = 1'b0;
        n = 0;
        while (!r3_valid && n < 30) begin
            tick();
            n++;
        end
        check("t6_latency", n, 32'd5);
        check("t6_data", {16'd0, r3_data}, 32'h0100);
        check("t6_opcode", {30'd0, r3_opcode}, 32'd1);
        r3_ready = 1'b1;
        tick();
        r3_ready = 1'b0;
        check("t6_valid_clear", {31'd0, r3_valid}, 32'd0);
        check("t6_idle", {31'd0, busy3}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command stage for the 8-bit, 2-operand ALU (`op_start`/A/B/opcode in, 16-bit OUT registered one cycle after `op_start` is sampled).
- Buffers commands from a valid/ready producer in a small FIFO.
- Issues one `op_start` pulse per command with stable operands, waits the ALU latency, then captures OUT.
- Presents each result on a valid/ready result port, strictly in order, one command in flight at a time.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- RESULT_LAT, 1: cycles from the ALU sampling `op_start` to OUT being valid; at least 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous and active-high.
- cmd_valid  input  1  producer has a command.
- cmd_ready  output  1  FIFO can accept; equals (cmd_count < DEPTH).
- cmd_opcode  input  2  0=ADD, 1=MUL, 2=OR, 3=AND.
- cmd_a  input  8  operand A.
- cmd_b  input  8  operand B.
- alu_op_start  output  1  one-cycle issue pulse to the ALU.
- alu_a  output  8  operand A to the ALU, registered.
- alu_b  output  8  operand B to the ALU, registered.
- alu_opcode  output  2  opcode to the ALU, registered.
- alu_out  input  16  ALU OUT.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  16  captured ALU result.
- res_opcode  output  2  opcode that produced res_data.
- cmd_count  output  $clog2(DEPTH+1)  FIFO occupancy.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, `rst` high at a rising edge):
  - FIFO emptied, cmd_count=0, state=IDLE.
  - alu_op_start=0, alu_a=0, alu_b=0, alu_opcode=0.
  - res_valid=0, res_data=0, res_opcode=0, busy=0.
  - An in-flight command is dropped and produces no result.
  - `rst` has priority over all other inputs.
- Push: on cmd_valid && cmd_ready the command is written at the tail.
  - When full, cmd_ready=0 and cmd_valid is ignored.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
- FSM has four states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if FIFO not empty, pop the head, load alu_a/alu_b/alu_opcode, set alu_op_start=1, go to ISSUE.
  - ISSUE (exactly 1 cycle, alu_op_start=1): then clear alu_op_start, load wait counter=RESULT_LAT, go to WAIT.
  - WAIT: decrement the counter each cycle. At the edge where it reaches 0:
    - res_data <= alu_out, res_opcode <= alu_opcode, res_valid <= 1.
    - Go to HOLD.
  - HOLD: res_data and res_opcode stay stable while res_valid && !res_ready.
    - On res_ready: clear res_valid.
    - If the FIFO is non-empty, pop and go straight to ISSUE (no IDLE bubble); otherwise go to IDLE.
- alu_a/alu_b/alu_opcode are held constant from ISSUE until the next issue.
- Latency with empty pipeline, RESULT_LAT=1:
  - Command accepted at edge E0, alu_op_start high during E1..E2.
  - ALU samples at E2, result captured at E3, res_valid high after E3.
  - Total: 3 cycles accept-to-valid.
- Throughput with res_ready tied high: one result per RESULT_LAT+2 cycles.
- Width rules: res_data is the full 16-bit ALU value, carry and product preserved; no truncation or sign handling.
- Pointers wrap modulo DEPTH. Full and empty are derived from cmd_count.
- cmd_ready depends only on registered count (no combinational path from res_ready).

Decomposition:
- Package alu_pkg holds:
  - opcode_e enum: OP_ADD=0, OP_MUL=1, OP_OR=2, OP_AND=3.
  - alu_cmd_t struct: opcode, a, b.
  - seq_state_e enum: IDLE, ISSUE, WAIT, HOLD.
- One sub-module: alu_cmd_fifo, parameterised by DEPTH and storing alu_cmd_t.
  - Ports: push, pop, din, dout, count, full, empty.
- FSM and capture logic live in alu_cmd_sequencer.

Test Plan:
1. Reset then single ADD a=0xFF, b=0xFF, res_ready=1 -> alu_op_start high for exactly one cycle; res_valid 3 cycles after accept; res_data=0x01FE, res_opcode=0.
2. MUL 0xFF×0xFF, then OR 0xA5|0x5A, then AND 0xF0&0x3C pushed back-to-back -> results in order 0xFE01, 0x00FF, 0x0030; issues 3 cycles apart.
3. Push 5 commands with res_ready=0 -> first issued; FIFO then fills with the remaining 4.
   - cmd_ready=0 at cmd_count=4; a sixth push attempt is not accepted.
   - First result is held stable for 10 cycles, then drains in order when res_ready=1.
4. Backpressure: res_ready toggled 0,1,0,1 during HOLD -> res_data unchanged until the handshake; no result lost or duplicated.
5. `rst` asserted during WAIT with 2 commands queued -> next cycle all outputs are at reset values and cmd_count=0; no res_valid for the dropped commands; a new ADD 1+2 afterwards gives 0x0003.
6. RESULT_LAT=3 build, MUL 0x10×0x10 -> res_valid 5 cycles after accept; res_data=0x0100.
